crc_32_channel_ctrl: RTL and testbench
======================================

# crc_32_channel_ctrl

Sequencer and round-robin arbiter placed in front of `crc_32_multi_channel`, sharing its single combinational CRC32 datapath among `CHANNEL` requesters. Each requester streams 32-bit words tagged first/last. The block issues the per-channel clear and update strobes to the engine, acknowledges each consumed word, and reports the final CRC of every packet with its channel number. It sits in the NI between the packet framing logic and the CRC engine.

## Interface
- `CHANNEL`, 4, number of requesters and CRC channels; must match the engine instance.
- `CHw`, localparam `log2(CHANNEL)` using the engine's log2 (minimum 1).

- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-low reset.
- `req_valid` in `CHANNEL`: per-channel word available.
- `req_first` in `CHANNEL`: word is the first of a packet.
- `req_last` in `CHANNEL`: word is the last of a packet.
- `req_data` in `CHANNEL*32`: channel i occupies `[32*i+31:32*i]`.
- `req_ack` out `CHANNEL`: one-hot, 1-cycle pulse; the word is consumed.
- `crc_channel` out `CHw`: to engine `channel_in`.
- `crc_clr` out 1: to engine `crc_reset`.
- `crc_enable` out 1: to engine `crc_enable`.
- `crc_data` out 32: to engine `data_in`.
- `crc_in` in 32: from engine `crc_out` (the selected channel's register).
- `result_valid` out 1: 1-cycle pulse; the packet CRC is available.
- `result_chan` out `CHw`: channel of the reported CRC.
- `result_crc` out 32: final CRC, with no inversion or reflection.
- `busy` out 1: FSM is not in IDLE.

## Operation
- FSM states: IDLE, CLR, UPD, RES. Registers: `state`, `grant[CHw]`, `rr_ptr[CHw]`, result registers.
- **IDLE**
  - If any `req_valid`, pick the winner as the lowest index ≥ `rr_ptr` with `req_valid`=1, wrapping modulo `CHANNEL`, and register it in `grant`.
  - Go to CLR if `req_first[winner]`, otherwise go to UPD.
  - If there is no request, stay in IDLE.
- **CLR**
  - `crc_clr`=1 and `crc_channel`=`grant`. The engine zeroes that channel at the clock edge.
  - Next state is UPD.
- **UPD**
  - If `req_valid[grant]`=1:
    - Assert `crc_enable`=1, `crc_data`=`req_data[grant]` and `req_ack[grant]`=1.
    - Set `rr_ptr` ← `grant`+1, wrapping to 0 past `CHANNEL`-1.
    - Go to RES if `req_last[grant]`, otherwise go to IDLE.
  - If `req_valid[grant]`=0 (protocol violation): no enable, no ack, go to IDLE, and `rr_ptr` is unchanged.
- **RES**
  - `crc_channel`=`grant`. Register `result_crc` ← `crc_in` and `result_chan` ← `grant`, and set `result_valid` ← 1 for the next cycle.
  - Next state is IDLE.
- Engine strobes:
  - `crc_channel` = `grant` in CLR, UPD and RES, and 0 in IDLE.
  - `crc_clr`, `crc_enable` and `crc_data` are 0 outside their own states.
- The CRC engine is never cleared implicitly. The first word of every packet goes through CLR.
- Requesters hold valid, first, last and data stable until ack. A word with both first and last goes CLR→UPD→RES.
- Interleaving: packets on different channels may interleave word by word. Each channel's CRC state lives in the engine.

## Timing
- Reset (`reset`=0 at a rising edge):
  - State goes to IDLE, and `grant` and `rr_ptr` go to 0.
  - All outputs are 0: `req_ack`, `crc_clr`, `crc_enable`, `crc_data`, `crc_channel`, `result_valid`, `result_chan`, `result_crc` and `busy`.
- Reset mid-packet aborts the current word with no ack. The engine contents are not guaranteed; the next first word clears them.
- Word latency, from the IDLE cycle (T) in which it wins:
  - Non-first word: ack at T+1.
  - First word: ack at T+2.
  - Last word: `result_valid` at T+3, or T+4 if the word is both first and last.
- Throughput is at most one word per 2 cycles, 3 with a first word, plus one RES cycle per packet.
- `req_ack` and the engine strobes are combinational decodes of the registered state and `grant`.
- `result_*` are registered. `result_crc` and `result_chan` hold their value until the next RES.
- `busy` = (state ≠ IDLE).
- A single active requester with `CHANNEL`=1 is served every IDLE visit; the pointer wrap stays at 0.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles with all `req_valid`=1 → every output stays 0 and no ack is issued.
- **Known CRCs:** ch0 sends one word, first+last, data 0x00000000 → ack at T+2, `result_valid` at T+4 with `result_crc`=0x00000000 and `result_chan`=0. Repeat with data 0x00000001 → `result_crc`=0x04C11DB7.
- **Two-word packet:** ch2 sends 0x00000001 (first) then 0x00000000 (last) → `result_crc` matches the reference model of two engine updates from 0. Exactly one `crc_clr` pulse is seen.
- **Round-robin:** all four channels hold valid with single-word first+last packets → acks occur in order 0,1,2,3,0. No channel is served twice while another is waiting.
- **Interleaving:** ch1 and ch3 alternate 3-word packets → each `result_crc` equals its stand-alone value, and `result_chan` is correct.
- **Protocol violation and mid-packet reset:**
  - Drop `req_valid[1]` during CLR → no ack, no enable, FSM returns to IDLE.
  - Assert reset during UPD → outputs are 0 on the next cycle, and a fresh first+last 0x00000001 still yields 0x04C11DB7.

Source files
------------

// File: rtl/crc_32_channel_ctrl.sv
// crc_32_channel_ctrl: round-robin sequencer that shares one combinational CRC32 engine among
// CHANNEL word-streaming requesters. It issues the engine clear/update strobes, acknowledges
// consumed words and reports the final CRC of each packet with its channel number.
module crc_32_channel_ctrl #(
   parameter int unsigned CHANNEL = 4,
   localparam int unsigned CHw = (CHANNEL > 1) ? $clog2(CHANNEL) : 1
) (
   input  logic                  clk_i,
   input  logic                  reset_ni,
   input  logic [CHANNEL-1:0]    req_valid_i,
   input  logic [CHANNEL-1:0]    req_first_i,
   input  logic [CHANNEL-1:0]    req_last_i,
   input  logic [CHANNEL*32-1:0] req_data_i,
   output logic [CHANNEL-1:0]    req_ack_o,
   output logic [CHw-1:0]        crc_channel_o,
   output logic                  crc_clr_o,
   output logic                  crc_enable_o,
   output logic [31:0]           crc_data_o,
   input  logic [31:0]           crc_in_i,
   output logic                  result_valid_o,
   output logic [CHw-1:0]        result_chan_o,
   output logic [31:0]           result_crc_o,
   output logic                  busy_o
);

   typedef enum logic [1:0] {
      StIdle,
      StClr,
      StUpd,
      StRes
   } state_e;

   state_e         state_q, state_d;
   logic [CHw-1:0] grant_q, grant_d;
   logic [CHw-1:0] rr_ptr_q, rr_ptr_d;

   logic           result_valid_q;
   logic [CHw-1:0] result_chan_q;
   logic [31:0]    result_crc_q;

   logic [31:0]    data_arr [CHANNEL];
   logic           any_valid;
   logic [CHw-1:0] winner;
   logic [CHw-1:0] cand;
   logic [CHw-1:0] grant_inc;

   // Split the flat request data bus into one word per channel.
   always_comb begin
      for (int i = 0; i < int'(CHANNEL); i++) begin
         data_arr[i] = req_data_i[32*i +: 32];
      end
   end

   // Round-robin pick: scan offsets from high to low so the smallest offset from rr_ptr wins.
   always_comb begin
      any_valid = 1'b0;
      winner    = '0;
      cand      = '0;
      for (int k = int'(CHANNEL) - 1; k >= 0; k--) begin
         cand = CHw'((int'(rr_ptr_q) + k) % int'(CHANNEL));
         if (req_valid_i[cand]) begin
            any_valid = 1'b1;
            winner    = cand;
         end
      end
   end

   // Pointer advance past the granted channel, wrapping at CHANNEL-1.
   always_comb begin
      grant_inc = (grant_q == CHw'(CHANNEL - 1)) ? '0 : grant_q + CHw'(1);
   end

   // Next-state logic and engine/ack strobes decoded from the registered state and grant.
   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      rr_ptr_d      = rr_ptr_q;
      req_ack_o     = '0;
      crc_channel_o = '0;
      crc_clr_o     = 1'b0;
      crc_enable_o  = 1'b0;
      crc_data_o    = '0;

      unique case (state_q)
         StIdle: begin
            if (any_valid) begin
               grant_d = winner;
               state_d = req_first_i[winner] ? StClr : StUpd;
            end
         end
         StClr: begin
            crc_channel_o = grant_q;
            crc_clr_o     = 1'b1;
            state_d       = StUpd;
         end
         StUpd: begin
            crc_channel_o = grant_q;
            if (req_valid_i[grant_q]) begin
               crc_enable_o       = 1'b1;
               crc_data_o         = data_arr[grant_q];
               req_ack_o[grant_q] = 1'b1;
               rr_ptr_d           = grant_inc;
               state_d            = req_last_i[grant_q] ? StRes : StIdle;
            end else begin
               // Requester withdrew its word: drop the grant without consuming anything.
               state_d = StIdle;
            end
         end
         StRes: begin
            crc_channel_o = grant_q;
            state_d       = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // A word in flight when reset arrives is aborted, so no strobe may escape that cycle.
      if (!reset_ni) begin
         req_ack_o     = '0;
         crc_channel_o = '0;
         crc_clr_o     = 1'b0;
         crc_enable_o  = 1'b0;
         crc_data_o    = '0;
      end
   end

   // FSM, grant and round-robin pointer registers.
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q  <= StIdle;
         grant_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // Capture the engine output for the granted channel while in RES; hold it until the next RES.
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         result_valid_q <= 1'b0;
         result_chan_q  <= '0;
         result_crc_q   <= '0;
      end else begin
         result_valid_q <= (state_q == StRes);
         if (state_q == StRes) begin
            result_chan_q <= grant_q;
            result_crc_q  <= crc_in_i;
         end
      end
   end

   assign result_valid_o = result_valid_q;
   assign result_chan_o  = result_chan_q;
   assign result_crc_o   = result_crc_q;
   assign busy_o         = (state_q != StIdle);

   a_ack_onehot : assert property (@(posedge clk_i) disable iff (!reset_ni)
      $onehot0(req_ack_o));
   a_strobe_excl : assert property (@(posedge clk_i) disable iff (!reset_ni)
      !(crc_clr_o && crc_enable_o));

endmodule

// File: tb/tb_crc_32_channel_ctrl.sv
// Bench for crc_32_channel_ctrl: behavioural multi-channel CRC engine, directed timing vectors,
// hand-written corner sequences and a randomized scoreboard run.
module tb_crc_32_channel_ctrl;

   localparam int CH = 4;
   localparam logic [31:0] POLY = 32'h04C11DB7;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [CH-1:0]     req_valid, req_first, req_last;
   logic [CH*32-1:0]  req_data;
   logic [31:0]       tb_data [CH];
   logic [CH-1:0]     req_ack;
   logic [1:0]        crc_channel;
   logic              crc_clr, crc_enable;
   logic [31:0]       crc_data, crc_in;
   logic              result_valid;
   logic [1:0]        result_chan;
   logic [31:0]       result_crc;
   logic              busy;

   always #5 clk = ~clk;

   for (genvar g = 0; g < CH; g++) begin : g_pack
      assign req_data[32*g +: 32] = tb_data[g];
   end

   crc_32_channel_ctrl #(.CHANNEL(CH)) dut (
      .clk_i         (clk),
      .reset_ni      (reset_n),
      .req_valid_i   (req_valid),
      .req_first_i   (req_first),
      .req_last_i    (req_last),
      .req_data_i    (req_data),
      .req_ack_o     (req_ack),
      .crc_channel_o (crc_channel),
      .crc_clr_o     (crc_clr),
      .crc_enable_o  (crc_enable),
      .crc_data_o    (crc_data),
      .crc_in_i      (crc_in),
      .result_valid_o(result_valid),
      .result_chan_o (result_chan),
      .result_crc_o  (result_crc),
      .busy_o        (busy)
   );

   // Engine stand-in: word-wide update, xor the word in then 32 polynomial steps.
   function automatic logic [31:0] eng_step(input logic [31:0] c, input logic [31:0] d);
      logic [31:0] r;
      r = c ^ d;
      for (int i = 0; i < 32; i++) r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
      return r;
   endfunction

   logic [31:0] eng [CH];
   assign crc_in = eng[crc_channel];
   always @(posedge clk) begin
      if (crc_clr) eng[crc_channel] <= 32'h0;
      else if (crc_enable) eng[crc_channel] <= eng_step(eng[crc_channel], crc_data);
   end

   // Reference: packet as one bit string, M(x)*x^32 mod P, fed serially MSB first.
   function automatic logic [31:0] ref_crc(input logic [31:0] w [$]);
      logic [31:0] c;
      logic        fb;
      c = '0;
      foreach (w[k]) begin
         for (int b = 31; b >= 0; b--) begin
            fb = c[31] ^ w[k][b];
            c  = c << 1;
            if (fb) c = c ^ POLY;
         end
      end
      return c;
   endfunction

   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [31:0] d;
      bit          f;
      bit          l;
   } word_t;

   word_t       wq    [CH][$];
   logic [31:0] exp_q [CH][$];
   int          ack_log [$];
   logic [CH-1:0] ack_evt = '0;
   int          clr_cnt = 0;
   int          skips [CH];
   bit          sb_on = 1'b0;

   // Monitor on the falling edge: ack bookkeeping, fairness and result scoreboard.
   always @(negedge clk) begin
      ack_evt = req_ack;
      if (crc_clr) clr_cnt++;
      if (sb_on) begin
         check("ack_onehot", 64'($countones(req_ack) <= 1), 64'd1);
         for (int c = 0; c < CH; c++) begin
            if (req_ack[c]) begin
               ack_log.push_back(c);
               for (int j = 0; j < CH; j++) begin
                  if (j == c) skips[j] = 0;
                  else if (req_valid[j]) begin
                     skips[j]++;
                     check($sformatf("rr_fairness ch%0d", j), 64'(skips[j] <= CH - 1), 64'd1);
                  end else skips[j] = 0;
               end
            end
         end
         if (result_valid) begin
            check("result_pending", 64'(exp_q[result_chan].size() > 0), 64'd1);
            if (exp_q[result_chan].size() > 0) begin
               check($sformatf("result_crc ch%0d", result_chan), 64'(result_crc),
                     64'(exp_q[result_chan].pop_front()));
            end
         end
      end
   end

   task automatic add_pkt(input int ch, input int n);
      logic [31:0] ws [$];
      word_t       wd;
      for (int i = 0; i < n; i++) begin
         wd.d = $urandom;
         wd.f = (i == 0);
         wd.l = (i == n - 1);
         ws.push_back(wd.d);
         wq[ch].push_back(wd);
      end
      exp_q[ch].push_back(ref_crc(ws));
   endtask

   // Requester model: present queued words, hold until acked, optional random gaps.
   task automatic run_feed(input int budget, input bit gaps);
      bit    pres [CH];
      bit    done;
      word_t tmp;
      done = 1'b0;
      foreach (pres[c]) pres[c] = 1'b0;
      for (int cyc = 0; cyc < budget && !done; cyc++) begin
         @(posedge clk);
         #1;
         for (int c = 0; c < CH; c++) begin
            if (ack_evt[c] && pres[c]) begin
               tmp     = wq[c].pop_front();
               pres[c] = 1'b0;
            end
            if (!pres[c] && wq[c].size() > 0 && (!gaps || $urandom_range(3) != 0)) pres[c] = 1'b1;
            req_valid[c] = pres[c];
            if (pres[c]) begin
               tb_data[c]   = wq[c][0].d;
               req_first[c] = wq[c][0].f;
               req_last[c]  = wq[c][0].l;
            end
         end
         done = 1'b1;
         for (int c = 0; c < CH; c++) begin
            if (wq[c].size() != 0 || exp_q[c].size() != 0 || pres[c]) done = 1'b0;
         end
      end
      check("feed_drained", 64'(done), 64'd1);
      @(negedge clk);
      #1;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (!busy) ok = 1'b1;
         else begin
            @(negedge clk);
            #1;
         end
      end
      check("idle_timeout", 64'(ok), 64'd1);
   endtask

   typedef struct {
      int          ch;
      bit          f;
      bit          l;
      logic [31:0] d;
      int          ack_cyc;
      int          res_cyc;
      int          clr;
      logic [31:0] crc;
   } vec_t;

   vec_t vecs [7];

   // One word from one channel; cycle 0 is the IDLE cycle in which it wins.
   task automatic run_vec(input int idx, input vec_t v);
      int            c0;
      logic [CH-1:0] exp_ack;
      wait_idle();
      c0              = clr_cnt;
      req_valid[v.ch] = 1'b1;
      req_first[v.ch] = v.f;
      req_last[v.ch]  = v.l;
      tb_data[v.ch]   = v.d;
      for (int cyc = 0; cyc < 6; cyc++) begin
         if (cyc > 0) @(negedge clk);
         #1;
         exp_ack = (cyc == v.ack_cyc) ? (CH'(1) << v.ch) : '0;
         check($sformatf("vec%0d ack c%0d", idx, cyc), 64'(req_ack), 64'(exp_ack));
         check($sformatf("vec%0d rvalid c%0d", idx, cyc), 64'(result_valid),
               64'(cyc == v.res_cyc));
         if (cyc == v.res_cyc) begin
            check($sformatf("vec%0d crc", idx), 64'(result_crc), 64'(v.crc));
            check($sformatf("vec%0d chan", idx), 64'(result_chan), 64'(v.ch));
         end
         if (req_ack[v.ch]) begin
            @(posedge clk);
            #1;
            req_valid[v.ch] = 1'b0;
         end
      end
      check($sformatf("vec%0d clr_count", idx), 64'(clr_cnt - c0), 64'(v.clr));
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      @(negedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w [$];
      int          exp_order [5];
      bit          got;

      // Reset: every requester valid while reset is held.
      reset_n   = 1'b0;
      req_valid = '1;
      req_first = '1;
      req_last  = '1;
      for (int c = 0; c < CH; c++) tb_data[c] = $urandom;
      foreach (skips[j]) skips[j] = 0;
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         check($sformatf("reset ctl %0d", i), 64'({req_ack, crc_channel, crc_clr, crc_enable,
               result_valid, result_chan, busy}), 64'd0);
         check($sformatf("reset data %0d", i), 64'({crc_data, result_crc}), 64'd0);
      end
      req_valid = '0;
      reset_n   = 1'b1;

      // Directed single-word timing vectors.
      vecs[0] = '{0, 1'b1, 1'b1, 32'h0000_0000, 2, 4, 1, 32'h0000_0000};
      vecs[1] = '{0, 1'b1, 1'b1, 32'h0000_0001, 2, 4, 1, 32'h04C1_1DB7};
      w = '{32'h1, 32'h0};
      vecs[2] = '{2, 1'b1, 1'b0, 32'h0000_0001, 2, -1, 1, 32'h0};
      vecs[3] = '{2, 1'b0, 1'b1, 32'h0000_0000, 1, 3, 0, ref_crc(w)};
      w = '{32'h1, 32'h0, 32'hDEAD_BEEF};
      vecs[4] = '{3, 1'b1, 1'b0, 32'h0000_0001, 2, -1, 1, 32'h0};
      vecs[5] = '{3, 1'b0, 1'b0, 32'h0000_0000, 1, -1, 0, 32'h0};
      vecs[6] = '{3, 1'b0, 1'b1, 32'hDEAD_BEEF, 1, 3, 0, ref_crc(w)};
      for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

      // Round-robin with every channel holding a single-word packet.
      wait_idle();
      pulse_reset();
      ack_log.delete();
      foreach (skips[j]) skips[j] = 0;
      sb_on = 1'b1;
      add_pkt(0, 1);
      add_pkt(0, 1);
      for (int c = 1; c < CH; c++) add_pkt(c, 1);
      run_feed(200, 1'b0);
      exp_order = '{0, 1, 2, 3, 0};
      check("rr_ack_count", 64'(ack_log.size()), 64'd5);
      for (int i = 0; i < 5 && i < ack_log.size(); i++) begin
         check($sformatf("rr_order %0d", i), 64'(ack_log[i]), 64'(exp_order[i]));
      end

      // Interleaved three-word packets on channels 1 and 3.
      for (int p = 0; p < 2; p++) begin
         add_pkt(1, 3);
         add_pkt(3, 3);
      end
      run_feed(300, 1'b0);
      sb_on = 1'b0;

      // Requester 1 withdraws its first word while the FSM is clearing.
      wait_idle();
      req_valid[1] = 1'b1;
      req_first[1] = 1'b1;
      req_last[1]  = 1'b0;
      tb_data[1]   = 32'h1234_5678;
      @(negedge clk);
      #1;
      check("viol clr", 64'({crc_clr, crc_channel}), 64'({1'b1, 2'd1}));
      req_valid[1] = 1'b0;
      @(negedge clk);
      #1;
      check("viol upd busy", 64'(busy), 64'd1);
      check("viol no ack/enable", 64'({req_ack, crc_enable}), 64'd0);
      @(negedge clk);
      #1;
      check("viol back idle", 64'(busy), 64'd0);

      // Reset while a first+last word sits in UPD, then the same word again.
      wait_idle();
      req_valid[0] = 1'b1;
      req_first[0] = 1'b1;
      req_last[0]  = 1'b1;
      tb_data[0]   = 32'h0000_0001;
      @(negedge clk);
      #1;
      @(negedge clk);
      #1;
      check("midrst in upd", 64'(busy), 64'd1);
      reset_n = 1'b0;
      #1;
      check("midrst no ack", 64'({req_ack, crc_enable}), 64'd0);
      @(negedge clk);
      #1;
      check("midrst ctl zero", 64'({req_ack, crc_channel, crc_clr, crc_enable, result_valid,
            result_chan, busy}), 64'd0);
      check("midrst data zero", 64'({crc_data, result_crc}), 64'd0);
      reset_n = 1'b1;
      got     = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         #1;
         if (result_valid) begin
            got = 1'b1;
            check("midrst crc", 64'(result_crc), 64'h04C1_1DB7);
         end
         if (req_ack[0]) begin
            @(posedge clk);
            #1;
            req_valid[0] = 1'b0;
         end
      end
      check("midrst result seen", 64'(got), 64'd1);

      // Randomized traffic against the scoreboard.
      wait_idle();
      foreach (skips[j]) skips[j] = 0;
      sb_on = 1'b1;
      for (int p = 0; p < 6; p++) begin
         for (int c = 0; c < CH; c++) add_pkt(c, int'($urandom_range(4, 1)));
      end
      run_feed(6000, 1'b1);
      sb_on = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
